// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared types for the DSP output chain
package dsp_pkg;

  typedef enum logic {SETTLE, RUN} decim_state_t;

  // Counter width that still holds the value n, with a 1-bit floor for n==0/1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is deliberately left unreset; readers mask the head when empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - discards FIR fill transient, keeps every DECIM-th sample, buffers output
module fir_decimator
  import dsp_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int DECIM      = 4,
  parameter int SKIP       = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_en,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow,
  input  logic                        clear_ovf,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int SKIP_W = cnt_width(SKIP);
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

  decim_state_t      state;
  logic [SKIP_W-1:0] skip_cnt;
  logic [PH_W-1:0]   phase;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              keep;
  logic              pop;
  logic              push;
  logic              drop;

  assign keep = (state == RUN) && in_en && (phase == '0);
  assign pop  = !fifo_empty && out_ready;
  // A full FIFO still accepts when the head leaves on the same edge
  assign push = keep && (!fifo_full || pop);
  assign drop = keep && !push;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= (SKIP == 0) ? RUN : SETTLE;
      skip_cnt <= '0;
      phase    <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_en) begin
        case (state)
          SETTLE: begin
            skip_cnt <= skip_cnt + 1'b1;
            if (skip_cnt == SKIP_W'(SKIP - 1)) begin
              state <= RUN;
              phase <= '0;
            end
          end
          RUN: phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
          default: state <= SETTLE;
        endcase
      end
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (in_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - randomized self-checking bench for fir_decimator
module tb_fir_decimator;

  localparam int DATA_W = 24;
  localparam int DECIM  = 4;
  localparam int SKIP   = 32;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] in_data;
  logic              in_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
  logic              clear_ovf;
  logic [3:0]        level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] m_q[$];
  int                m_k;
  bit                m_ovf;

  fir_decimator #(
    .DATA_W     (DATA_W),
    .DECIM      (DECIM),
    .SKIP       (SKIP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_en     (in_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the k-th enabled sample since reset is kept iff it lies past
  // the fill and is a multiple of DECIM beyond it; FIFO is a plain queue.
  task automatic step();
    bit pop_m, keep_m, drop_m;
    if (!reset_n) begin
      m_q.delete();
      m_k   = 0;
      m_ovf = 0;
    end else begin
      pop_m  = (m_q.size() > 0) && out_ready;
      keep_m = 0;
      if (in_en) begin
        keep_m = (m_k >= SKIP) && (((m_k - SKIP) % DECIM) == 0);
        m_k++;
      end
      drop_m = keep_m && (m_q.size() == DEPTH) && !pop_m;
      if (pop_m) void'(m_q.pop_front());
      if (keep_m && !drop_m) m_q.push_back(in_data);
      if (drop_m) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("out_data",  32'(out_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check("level",     32'(level),     32'(m_q.size()));
    check("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  // mode: 0 idle, 1 enable every cycle, 2 alternate, 3 random enable
  task automatic run(input int n, input int mode, input int rdy_mode, input bit seq_data);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       in_en = 1'b0;
        1:       in_en = 1'b1;
        2:       in_en = (i % 2 == 0);
        default: in_en = 1'($urandom_range(1, 0));
      endcase
      in_data   = seq_data ? DATA_W'(m_k) : DATA_W'($urandom);
      out_ready = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : 1'(rdy_mode);
      step();
    end
    in_en     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_en   = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    in_en     = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    m_k       = 0;
    m_ovf     = 0;
    step();
    step();
    check("reset_level", 32'(level), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    reset_n = 1'b1;

    // Settle and first output: continuous sequential data, sink always ready
    run(31, 1, 1, 1'b1);
    check("pre_settle_valid", 32'(out_valid), 32'd0);
    run(1, 1, 1, 1'b1);
    check("sample31_dropped", 32'(out_valid), 32'd0);
    run(1, 1, 1, 1'b1);
    check("first_out", 32'(out_data), 32'd32);
    run(40, 1, 1, 1'b1);

    // Gapped enable and random backpressure
    run(120, 2, 2, 1'b0);
    run(200, 3, 2, 1'b0);

    // Backpressure fill: 61 enabled samples yield exactly 8 kept
    do_reset();
    run(SKIP + 7 * DECIM + 1, 1, 0, 1'b1);
    check("fill_level", 32'(level), 32'd8);
    check("fill_ovf", 32'(overflow), 32'd0);
    check("fill_head", 32'(out_data), 32'd32);
    run(DECIM, 1, 0, 1'b1);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head", 32'(out_data), 32'd32);

    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full with simultaneous pop on the kept cycle
    run(DECIM - 1, 1, 0, 1'b1);
    in_en = 1'b1; in_data = DATA_W'(m_k); out_ready = 1'b1;
    step();
    in_en = 1'b0; out_ready = 1'b0;
    check("full_pop_level", 32'(level), 32'd8);
    check("full_pop_ovf", 32'(overflow), 32'd0);

    // Clear and drop on the same edge: drop wins
    run(DECIM - 1, 1, 0, 1'b1);
    in_en = 1'b1; in_data = DATA_W'(m_k); clear_ovf = 1'b1;
    step();
    in_en = 1'b0; clear_ovf = 1'b0;
    check("clr_vs_drop", 32'(overflow), 32'd1);

    // Mid-stream reset at level 5
    run(3, 0, 1, 1'b0);
    check("level5", 32'(level), 32'd5);
    do_reset();
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    run(SKIP, 1, 1, 1'b0);
    check("post_rst_settle", 32'(out_valid), 32'd0);

    // Signed extremes, bit-exact
    in_en = 1'b1; in_data = 24'h800000; out_ready = 1'b0;
    step();
    check("neg_full", 32'(out_data), 32'h0080_0000);
    run(DECIM - 1, 1, 0, 1'b0);
    in_en = 1'b1; in_data = 24'h7FFFFF;
    step();
    in_en = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pos_full", 32'(out_data), 32'h007F_FFFF);

    run(60, 3, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of the FIR low-pass filter: consumes one filtered sample per enabled clock and discards the filter's pipeline-fill transient. It keeps every DECIM-th sample and buffers the result in a small FIFO. The output uses a valid/ready handshake so slower consumers (DAC serialiser, bus bridge) can apply backpressure without stalling the filter.

## Interface
- DATA_W, 24, sample width; matches the FIR output width.
- DECIM, 4, decimation factor, ≥1; 1 = pass-through.
- SKIP, 32, enabled input samples discarded after reset (FIR fill: N_TAPS−1), ≥0.
- FIFO_DEPTH, 8, output buffer entries, power of two, ≥2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- in_data  in  DATA_W  filtered sample, signed two's complement.
- in_en  in  1  in_data is a new sample this cycle; tie high when the filter runs every clk.
- out_data  out  DATA_W  head-of-FIFO sample; 0 when out_valid=0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- overflow  out  1  sticky; set when a kept sample was dropped.
- clear_ovf  in  1  clears overflow.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Data are passed bit-exact; no rounding, scaling or sign change.
- The FSM has two states, SETTLE and RUN. Reset enters SETTLE with skip_cnt=0, or RUN directly if SKIP=0.
- SETTLE:
  - Each in_en increments skip_cnt; all samples are discarded.
  - The in_en that brings skip_cnt to SKIP is also discarded, and the next state is RUN with phase=0.
  - in_en=0 leaves all state unchanged.
- RUN:
  - On in_en, the sample is kept iff phase==0.
  - phase then increments, wrapping at DECIM−1→0, so the first post-settle sample is kept.
  - DECIM=1 keeps every sample.
- Push: a kept sample is written at wr_ptr if the FIFO is not full, or if it is full and a pop occurs the same cycle (out_valid & out_ready).
- Drop: otherwise the sample is dropped, overflow←1, and phase still advances.
- Pop: out_valid & out_ready advances rd_ptr.
- Occupancy: simultaneous push and pop leave level unchanged.
- clear_ovf clears overflow; a same-cycle overflow event takes priority (overflow stays 1).
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from level.

## Timing
- Reset (reset_n=0 at a clk edge) sets:
  - out_valid=0, out_data=0, overflow=0, level=0;
  - FSM=SETTLE, skip_cnt=0, phase=0, pointers=0.
- Reset mid-operation flushes the FIFO contents and restarts SETTLE.
- Latency: a kept sample with in_en high at edge t gives out_valid=1 and out_data=sample after edge t if the FIFO was empty (1 cycle).
- out_data/out_valid are stable while out_valid=1 and out_ready=0.
- out_ready while out_valid=0 has no effect.
- Throughput: one push and one pop per cycle.
- level and overflow are registered and update on the same edge as the push/pop/drop.

## Structure
- Package dsp_pkg gets typedef enum logic {SETTLE, RUN} decim_state_t.
- Sub-module sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty, level) holds memory and pointers. fir_decimator holds the FSM, skip/phase counters, the drop decision and the overflow flag.
- The FIFO memory is not reset; out_data is masked to 0 when empty.

## Test plan
- Settle and first output:
  - Setup: SKIP=32, DECIM=4, in_en=1 continuously, in_data=cycle index 0,1,2…, out_ready=1.
  - Required: samples 32,36,40… appear at the output, each one cycle after input; nothing before sample 32.
- Gapped enable:
  - Setup: DECIM=4, in_en toggling 1/0.
  - Required: the kept sequence is identical to the continuous case (every 4th enabled sample). Idle cycles do not advance phase or skip_cnt.
- Backpressure fill:
  - Setup: out_ready=0, FIFO_DEPTH=8, DECIM=1, SKIP=0.
  - Required: after 8 samples, level=8 and overflow=0.
  - Required: the 9th sample sets overflow=1 and the head value remains sample 0.
- Full with simultaneous pop:
  - Setup: FIFO full, out_ready=1 on the same cycle a kept sample arrives.
  - Required: level stays 8, the sample is accepted and overflow stays 0.
- Overflow clear priority:
  - Setup: clear_ovf=1 with no new drop.
  - Required: overflow→0.
  - Setup: clear_ovf=1 on the same cycle as a drop.
  - Required: overflow stays 1.
- Mid-stream reset:
  - Setup: assert reset_n=0 for one cycle with level=5.
  - Required: level=0, out_valid=0 and out_data=0 next cycle, followed by a full SKIP discard before any new output.
- Signed values:
  - Setup: input 24'h800000 and 24'h7FFFFF.
  - Required: both appear bit-exact at out_data.
